// File: rtl/bsg_plru_stat_mem_ctrl_if.sv
// Bundle of the cache-side request/result handshakes and the stat-memory port
// for bsg_plru_stat_mem_ctrl. slave = controller view, master = environment view.
interface bsg_plru_stat_mem_ctrl_if #(
  parameter int sets_p = 64,
  parameter int ways_p = 8
);
  localparam int lg_sets_lp = $clog2(sets_p);
  localparam int lg_ways_lp = $clog2(ways_p);

  logic                  touch_v_i;
  logic [lg_sets_lp-1:0] touch_set_i;
  logic [lg_ways_lp-1:0] touch_way_i;
  logic                  touch_ready_o;
  logic                  victim_v_i;
  logic [lg_sets_lp-1:0] victim_set_i;
  logic                  victim_ready_o;
  logic                  victim_v_o;
  logic [lg_ways_lp-1:0] victim_way_o;
  logic                  victim_yumi_i;
  logic                  mem_v_o;
  logic                  mem_w_o;
  logic [lg_sets_lp-1:0] mem_addr_o;
  logic [ways_p-2:0]     mem_data_o;
  logic [ways_p-2:0]     mem_w_mask_o;
  logic [ways_p-2:0]     mem_data_i;

  modport slave (
    input  touch_v_i, touch_set_i, touch_way_i, victim_v_i, victim_set_i,
           victim_yumi_i, mem_data_i,
    output touch_ready_o, victim_ready_o, victim_v_o, victim_way_o,
           mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o
  );

  modport master (
    output touch_v_i, touch_set_i, touch_way_i, victim_v_i, victim_set_i,
           victim_yumi_i, mem_data_i,
    input  touch_ready_o, victim_ready_o, victim_v_o, victim_way_o,
           mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o
  );
endinterface

// File: rtl/bsg_plru_stat_mem_ctrl.sv
// Tree pseudo-LRU controller in front of a bit-masked 1RW stat memory:
// clears the memory after reset, turns touches into masked writes and victims into read+decode.
module bsg_plru_stat_mem_ctrl #(
  parameter int sets_p = 64,
  parameter int ways_p = 8
) (
  input logic                   clk_i,
  input logic                   reset_i,
  bsg_plru_stat_mem_ctrl_if.slave bus
);
  localparam int unsigned lg_sets_lp = $clog2(sets_p);
  localparam int unsigned lg_ways_lp = $clog2(ways_p);

  typedef enum logic [1:0] {INIT, IDLE, RD_WAIT, OUT} state_e;

  state_e                r_state;
  logic [lg_sets_lp-1:0] r_cnt;
  logic                  r_victim_v;
  logic [lg_ways_lp-1:0] r_victim_way;

  logic [ways_p-2:0]     w_touch_mask;
  logic [ways_p-2:0]     w_touch_data;
  logic [lg_ways_lp-1:0] w_tshift;
  logic [lg_ways_lp-1:0] w_tnode;
  logic [lg_ways_lp-1:0] w_dnode;
  logic [lg_ways_lp-1:0] w_dec_way;
  logic                  w_dbit;
  logic                  w_touch_acc;
  logic                  w_victim_acc;

  // Level l of the path: the node index is the level base plus the way's top l bits.
  always_comb begin
    w_touch_mask = '0;
    w_touch_data = '0;
    w_tshift     = '0;
    w_tnode      = '0;
    for (int unsigned l = 0; l < lg_ways_lp; l++) begin
      w_tshift = bus.touch_way_i >> (lg_ways_lp - 1 - l);
      w_tnode  = lg_ways_lp'((32'd1 << l) - 32'd1) + (w_tshift >> 1);
      w_touch_mask[w_tnode] = 1'b1;
      w_touch_data[w_tnode] = ~w_tshift[0];
    end
  end

  always_comb begin
    w_dnode   = '0;
    w_dec_way = '0;
    w_dbit    = 1'b0;
    for (int unsigned l = 0; l < lg_ways_lp; l++) begin
      w_dbit    = bus.mem_data_i[w_dnode];
      w_dec_way = (w_dec_way << 1) | lg_ways_lp'(w_dbit);
      w_dnode   = (w_dnode << 1) + lg_ways_lp'(1) + lg_ways_lp'(w_dbit);
    end
  end

  assign w_touch_acc  = ~reset_i & bus.touch_v_i & ((r_state == IDLE) | (r_state == OUT));
  assign w_victim_acc = ~reset_i & ~bus.touch_v_i & bus.victim_v_i & (r_state == IDLE);

  always_comb begin
    bus.touch_ready_o  = ~reset_i & ((r_state == IDLE) | (r_state == OUT));
    bus.victim_ready_o = ~reset_i & ~bus.touch_v_i & (r_state == IDLE);
    bus.mem_v_o        = 1'b0;
    bus.mem_w_o        = 1'b0;
    bus.mem_addr_o     = '0;
    bus.mem_data_o     = '0;
    bus.mem_w_mask_o   = '0;
    if (~reset_i && r_state == INIT) begin
      bus.mem_v_o      = 1'b1;
      bus.mem_w_o      = 1'b1;
      bus.mem_addr_o   = r_cnt;
      bus.mem_w_mask_o = '1;
    end else if (w_touch_acc) begin
      bus.mem_v_o      = 1'b1;
      bus.mem_w_o      = 1'b1;
      bus.mem_addr_o   = bus.touch_set_i;
      bus.mem_data_o   = w_touch_data;
      bus.mem_w_mask_o = w_touch_mask;
    end else if (w_victim_acc) begin
      bus.mem_v_o      = 1'b1;
      bus.mem_addr_o   = bus.victim_set_i;
    end
  end

  assign bus.victim_v_o   = r_victim_v;
  assign bus.victim_way_o = r_victim_way;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= INIT;
      r_cnt        <= '0;
      r_victim_v   <= 1'b0;
      r_victim_way <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == lg_sets_lp'(sets_p - 1)) r_state <= IDLE;
        end
        IDLE: if (w_victim_acc) r_state <= RD_WAIT;
        RD_WAIT: begin
          r_victim_way <= w_dec_way;
          r_victim_v   <= 1'b1;
          r_state      <= OUT;
        end
        OUT: if (bus.victim_yumi_i) begin
          r_victim_v <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_bsg_plru_stat_mem_ctrl.sv
// Bench for bsg_plru_stat_mem_ctrl: behavioural PLRU tree model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bsg_plru_stat_mem_ctrl;
  localparam int SETS  = 64;
  localparam int WAYS  = 8;
  localparam int NODES = WAYS - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  bsg_plru_stat_mem_ctrl_if #(.sets_p(SETS), .ways_p(WAYS)) bus ();

  bsg_plru_stat_mem_ctrl #(.sets_p(SETS), .ways_p(WAYS)) u_dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Stat memory: starts with junk so the post-reset sweep matters; read data valid next cycle.
  logic [NODES-1:0] mem [SETS];
  initial for (int i = 0; i < SETS; i++) mem[i] = NODES'($urandom);
  always @(negedge clk) begin
    if (bus.mem_v_o) begin
      if (bus.mem_w_o)
        mem[bus.mem_addr_o] = (mem[bus.mem_addr_o] & ~bus.mem_w_mask_o) |
                              (bus.mem_data_o & bus.mem_w_mask_o);
      else
        bus.mem_data_i = mem[bus.mem_addr_o];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Touch: walk from the leaf up, pointing every ancestor away from the touched child.
  task automatic touch_pat(input int w, output logic [NODES-1:0] m, output logic [NODES-1:0] d);
    int n, p;
    m = '0;
    d = '0;
    n = NODES + w;
    while (n > 0) begin
      p = (n - 1) / 2;
      m[p] = 1'b1;
      d[p] = (n == 2 * p + 1);
      n = p;
    end
  endtask

  function automatic int decode(input logic [NODES-1:0] t);
    int n = 0;
    while (n < NODES) n = 2 * n + 1 + int'(t[n]);
    return n - NODES;
  endfunction

  // Reference model state
  logic [NODES-1:0] mtree [SETS];
  int init_rem = 0;
  int phase    = 0;   // 0 idle, 1 read outstanding, 2 result held
  int pend_set = 0;
  int exp_vv   = 0;
  int exp_way  = 0;

  task automatic model_step();
    logic [NODES-1:0] m, d;
    int ph0;
    ph0 = phase;
    chk("victim_v_o", 32'(bus.victim_v_o), exp_vv);
    if (exp_vv == 1) chk("victim_way_o", 32'(bus.victim_way_o), exp_way);
    if (rst) begin
      chk("touch_ready_rst", 32'(bus.touch_ready_o), 0);
      chk("victim_ready_rst", 32'(bus.victim_ready_o), 0);
      chk("mem_v_rst", 32'(bus.mem_v_o), 0);
      init_rem = SETS;
      phase    = 0;
      exp_vv   = 0;
      for (int i = 0; i < SETS; i++) mtree[i] = '0;
    end else if (init_rem > 0) begin
      chk("touch_ready_init", 32'(bus.touch_ready_o), 0);
      chk("victim_ready_init", 32'(bus.victim_ready_o), 0);
      chk("mem_v_init", 32'(bus.mem_v_o), 1);
      chk("mem_w_init", 32'(bus.mem_w_o), 1);
      chk("mem_addr_init", 32'(bus.mem_addr_o), SETS - init_rem);
      chk("mem_mask_init", 32'(bus.mem_w_mask_o), (1 << NODES) - 1);
      chk("mem_data_init", 32'(bus.mem_data_o), 0);
      init_rem--;
    end else begin
      chk("touch_ready", 32'(bus.touch_ready_o), (ph0 != 1) ? 1 : 0);
      chk("victim_ready", 32'(bus.victim_ready_o), (ph0 == 0 && !bus.touch_v_i) ? 1 : 0);
      if (ph0 != 1 && bus.touch_v_i) begin
        touch_pat(int'(bus.touch_way_i), m, d);
        chk("mem_v_touch", 32'(bus.mem_v_o), 1);
        chk("mem_w_touch", 32'(bus.mem_w_o), 1);
        chk("mem_addr_touch", 32'(bus.mem_addr_o), int'(bus.touch_set_i));
        chk("mem_mask_touch", 32'(bus.mem_w_mask_o), int'(m));
        chk("mem_data_touch", 32'(bus.mem_data_o), int'(d));
        mtree[bus.touch_set_i] = (mtree[bus.touch_set_i] & ~m) | (d & m);
      end else if (ph0 == 0 && bus.victim_v_i) begin
        chk("mem_v_read", 32'(bus.mem_v_o), 1);
        chk("mem_w_read", 32'(bus.mem_w_o), 0);
        chk("mem_addr_read", 32'(bus.mem_addr_o), int'(bus.victim_set_i));
        chk("mem_mask_read", 32'(bus.mem_w_mask_o), 0);
        chk("mem_data_read", 32'(bus.mem_data_o), 0);
        pend_set = int'(bus.victim_set_i);
        phase = 1;
      end else begin
        chk("mem_v_quiet", 32'(bus.mem_v_o), 0);
      end
      if (ph0 == 1) begin
        exp_way = decode(mtree[pend_set]);
        exp_vv  = 1;
        phase   = 2;
      end
      if (ph0 == 2 && bus.victim_yumi_i) begin
        exp_vv = 0;
        phase  = 0;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_init();
    int n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.touch_ready_o) break;
      n++;
      tick();
    end
    chk("pin_init_cycles", n, 64);
    tick();
  endtask

  task automatic touch(input int s, input int w);
    bus.touch_v_i   = 1'b1;
    bus.touch_set_i = 6'(s);
    bus.touch_way_i = 3'(w);
    tick();
    bus.touch_v_i   = 1'b0;
  endtask

  task automatic victim_req(input int s, input int exp_lit);
    int lat = 1;
    bus.victim_v_i   = 1'b1;
    bus.victim_set_i = 6'(s);
    @(negedge clk);
    chk("pin_victim_ready", 32'(bus.victim_ready_o), 1);
    tick();
    bus.victim_v_i = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      if (bus.victim_v_o) break;
      lat++;
      tick();
    end
    chk("pin_latency", lat, 2);
    chk("pin_victim_way", 32'(bus.victim_way_o), exp_lit);
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("pin_hold_v", 32'(bus.victim_v_o), 1);
      chk("pin_hold_way", 32'(bus.victim_way_o), exp_lit);
    end
    tick();
    bus.victim_yumi_i = 1'b1;
    tick();
    bus.victim_yumi_i = 1'b0;
    @(negedge clk);
    chk("pin_drop", 32'(bus.victim_v_o), 0);
    tick();
  endtask

  initial begin
    bus.touch_v_i     = 1'b0;
    bus.touch_set_i   = '0;
    bus.touch_way_i   = '0;
    bus.victim_v_i    = 1'b0;
    bus.victim_set_i  = '0;
    bus.victim_yumi_i = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    count_init();

    victim_req(7, 0);

    bus.touch_v_i   = 1'b1;
    bus.touch_set_i = 6'd3;
    bus.touch_way_i = 3'd5;
    @(negedge clk);
    chk("pin_t35_addr", 32'(bus.mem_addr_o), 3);
    chk("pin_t35_mask", 32'(bus.mem_w_mask_o), 'h25);
    chk("pin_t35_data", 32'(bus.mem_data_o), 'h04);
    tick();
    bus.touch_v_i = 1'b0;

    touch(7, 0);
    victim_req(7, 4);
    touch(7, 4);
    victim_req(7, 2);

    bus.touch_v_i    = 1'b1;
    bus.touch_set_i  = 6'd7;
    bus.touch_way_i  = 3'd2;
    bus.victim_v_i   = 1'b1;
    bus.victim_set_i = 6'd7;
    @(negedge clk);
    chk("pin_both_vready", 32'(bus.victim_ready_o), 0);
    chk("pin_both_w", 32'(bus.mem_w_o), 1);
    tick();
    bus.touch_v_i = 1'b0;
    victim_req(7, 6);

    for (int c = 0; c < 3000; c++) begin
      bus.touch_v_i     = ($urandom_range(0, 2) == 0);
      bus.touch_set_i   = 6'($urandom);
      bus.touch_way_i   = 3'($urandom);
      bus.victim_v_i    = ($urandom_range(0, 2) == 0);
      bus.victim_set_i  = 6'($urandom_range(0, 7));
      bus.victim_yumi_i = bus.victim_v_o && ($urandom_range(0, 1) == 1);
      tick();
    end
    bus.touch_v_i  = 1'b0;
    bus.victim_v_i = 1'b0;
    repeat (4) begin
      bus.victim_yumi_i = bus.victim_v_o;
      tick();
    end
    bus.victim_yumi_i = 1'b0;

    bus.victim_v_i   = 1'b1;
    bus.victim_set_i = 6'd9;
    tick();
    bus.victim_v_i = 1'b0;
    tick();
    @(negedge clk);
    chk("pin_out_before_rst", 32'(bus.victim_v_o), 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("pin_rst_tready", 32'(bus.touch_ready_o), 0);
    tick();
    @(negedge clk);
    chk("pin_rst_vv", 32'(bus.victim_v_o), 0);
    tick();
    rst = 1'b0;
    count_init();
    victim_req(9, 0);
    victim_req(0, 0);
    victim_req(63, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bsg_plru_stat_mem_ctrl.md
Name: bsg_plru_stat_mem_ctrl

Overview:
- Controller that sits directly upstream of the 64-entry x 7-bit bit-masked 1RW stat memory.
- Owns tree pseudo-LRU state for an 8-way, 64-set cache.
- Turns cache "touch" (hit/fill) events into masked single-cycle writes, and "victim" requests into a read plus tree decode with a valid/yumi result.
- Clears the whole memory after reset before accepting any traffic.

Parameters:
- sets_p, 64, number of sets; memory depth. Power of two.
- ways_p, 8, associativity. Power of two, >= 2. Memory width = ways_p-1.
- lg_sets_lp, $clog2(sets_p), set index width. Derived.
- lg_ways_lp, $clog2(ways_p), way index width. Derived.

Ports:
- clk_i  in  1  Clock. The block has a single clock.
- reset_i  in  1  Synchronous, active-high reset.
- touch_v_i  in  1  Touch request valid.
- touch_set_i  in  lg_sets_lp  Set index of the touch.
- touch_way_i  in  lg_ways_lp  Way most recently used.
- touch_ready_o  out  1  Touch accepted when touch_v_i & touch_ready_o.
- victim_v_i  in  1  Victim lookup request valid.
- victim_set_i  in  lg_sets_lp  Set index for the lookup.
- victim_ready_o  out  1  Lookup accepted when victim_v_i & victim_ready_o.
- victim_v_o  out  1  Victim result valid.
- victim_way_o  out  lg_ways_lp  PLRU victim way.
- victim_yumi_i  in  1  Consumer takes result; only legal while victim_v_o=1.
- mem_v_o  out  1  Memory enable.
- mem_w_o  out  1  Memory write (1) / read (0).
- mem_addr_o  out  lg_sets_lp  Memory address.
- mem_data_o  out  ways_p-1  Write data.
- mem_w_mask_o  out  ways_p-1  Per-bit write mask.
- mem_data_i  in  ways_p-1  Read data. Valid the cycle after a read is issued.

Behaviour:
- Tree encoding: node 0 is the root; the children of node n are 2n+1 (left) and 2n+2 (right). Node bit 0 means the victim lies left.
- Touch way w (bits b_k MSB..LSB): at each level, the node on w's path is written with the complement of the corresponding bit of w.
  - The mask has exactly lg_ways_lp bits set; all other mask bits are 0.
  - 8-way case: node0 <= ~b2; node(1+b2) <= ~b1; node(3+2*b2+b1) <= ~b0.
- Victim decode: start at the root and follow node bits. Each visited bit becomes the next way bit, MSB first.
- FSM states: INIT, IDLE, RD_WAIT, OUT.
- Reset (any cycle, including mid-operation):
  - next state INIT, sweep counter 0, victim_v_o=0, victim_way_o=0.
  - Any pending result is discarded.
  - While reset_i=1: mem_v_o=0 and both ready outputs are 0.
- INIT:
  - Each cycle: mem_v_o=1, mem_w_o=1, mem_addr_o=counter, mask all ones, data all zeros. Counter increments.
  - After writing address sets_p-1, go to IDLE. Total of sets_p cycles after reset deasserts.
  - Both ready outputs are 0 throughout.
- IDLE:
  - touch_ready_o=1, victim_ready_o=~touch_v_i. Touch has priority over victim.
  - On touch accept: same-cycle masked write (mem_v_o=1, mem_w_o=1, addr=touch_set_i). Stay in IDLE.
  - On victim accept: same-cycle read (mem_v_o=1, mem_w_o=0, addr=victim_set_i). Go to RD_WAIT.
- RD_WAIT:
  - Both ready outputs are 0 and mem_v_o=0.
  - Decode mem_data_i into the victim register. Go to OUT.
- OUT:
  - victim_v_o=1; victim_way_o is held stable until yumi.
  - touch_ready_o=1; touches write normally and do not alter the held result. victim_ready_o=0.
  - On victim_yumi_i: go to IDLE. The next victim can be accepted the following cycle at the earliest.
- Latency: victim accepted in cycle t -> victim_v_o first high in cycle t+2.
- Back-to-back touches: one per cycle in IDLE/OUT. A touch followed by a victim lookup to the same set sees the updated bits.
- mem_v_o=0 in any cycle with no accepted request.
- Outside INIT, mem_data_o and mem_w_mask_o are 0 when mem_w_o=0.

Test Plan:
- Reset, then idle for 64 cycles -> ready outputs stay 0 for exactly 64 cycles. 64 writes to addresses 0..63 with mask 0x7F, data 0x00. Then touch_ready_o=1.
- After init, victim request on set 7 -> victim_v_o high 2 cycles later with way 0. Result held across 3 cycles without yumi; drops the cycle after yumi.
- Touch set 3 way 5 -> single write: addr 3, mask 0x25, data 0x04.
- Set 7: touch way 0, then victim -> way 4. Then touch way 4, then victim -> way 2.
- touch_v_i and victim_v_i both high in IDLE -> touch written that cycle, victim_ready_o=0. Victim is accepted the next cycle and reflects the touch.
- Assert reset while in OUT -> victim_v_o=0 the next cycle. Full 64-cycle sweep repeats, and victim on any set returns way 0.
